// File: rtl/nrf_cmd_pkg.sv
// Shared nRF24L01 command-interface definitions: opcodes, register map,
// reset values and the responder state enumeration.
package nrf_cmd_pkg;

    localparam logic [2:0] OP_R_REGISTER   = 3'b000;
    localparam logic [2:0] OP_W_REGISTER   = 3'b001;
    localparam logic [7:0] OP_R_RX_PAYLOAD = 8'h61;
    localparam logic [7:0] OP_W_TX_PAYLOAD = 8'hA0;
    localparam logic [7:0] OP_FLUSH_TX     = 8'hE1;
    localparam logic [7:0] OP_FLUSH_RX     = 8'hE2;
    localparam logic [7:0] OP_NOP          = 8'hFF;

    localparam logic [4:0] ADDR_CONFIG     = 5'h00;
    localparam logic [4:0] ADDR_EN_AA      = 5'h01;
    localparam logic [4:0] ADDR_EN_RXADDR  = 5'h02;
    localparam logic [4:0] ADDR_SETUP_AW   = 5'h03;
    localparam logic [4:0] ADDR_SETUP_RETR = 5'h04;
    localparam logic [4:0] ADDR_RF_CH      = 5'h05;
    localparam logic [4:0] ADDR_RF_SETUP   = 5'h06;
    localparam logic [4:0] ADDR_STATUS     = 5'h07;

    localparam int NUM_REGS = 8;

    localparam logic [7:0] RST_EN_AA      = 8'h3F;
    localparam logic [7:0] RST_EN_RXADDR  = 8'h03;
    localparam logic [7:0] RST_SETUP_AW   = 8'h03;
    localparam logic [7:0] RST_SETUP_RETR = 8'h03;
    localparam logic [7:0] RST_RF_CH      = 8'h02;
    localparam logic [7:0] RST_RF_SETUP   = 8'h0E;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA_RD,
        ST_DATA_WR,
        ST_DATA_PL,
        ST_IGNORE
    } state_e;

    // Entry 7 is STATUS, which is built from live flags rather than stored.
    function automatic logic [7:0] reg_reset_val(input logic [2:0] addr,
                                                 input logic [7:0] config_rst);
        case (addr)
            3'd0:    return config_rst;
            3'd1:    return RST_EN_AA;
            3'd2:    return RST_EN_RXADDR;
            3'd3:    return RST_SETUP_AW;
            3'd4:    return RST_SETUP_RETR;
            3'd5:    return RST_RF_CH;
            3'd6:    return RST_RF_SETUP;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] status_byte(input logic rx_dr, input logic tx_full);
        return {1'b0, rx_dr, 2'b00, (rx_dr ? 3'b000 : 3'b111), tx_full};
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with registered rising/falling edge pulses,
// used for the SPI clock.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] chain_q;
    logic              prev_q;
    logic              rise_q;
    logic              fall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q <= {STAGES{RST_VAL}};
            prev_q  <= RST_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
            prev_q  <= chain_q[STAGES-1];
            rise_q  <= chain_q[STAGES-1] & ~prev_q;
            fall_q  <= ~chain_q[STAGES-1] & prev_q;
        end
    end

    assign sync_o = chain_q[STAGES-1];
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/nrf_spi_responder.sv
// SPI mode-0 slave emulating the nRF24L01 command interface: 8-entry
// register file, single-byte TX/RX payloads and STATUS on every command byte.
module nrf_spi_responder
    import nrf_cmd_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] CONFIG_RST  = 8'h08
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       csn,
    input  logic       sck,
    input  logic       mosi,
    output logic       miso,
    input  logic       ce,
    input  logic [7:0] rx_payload_in,
    input  logic       rx_payload_load,
    input  logic       tx_ack,
    output logic [7:0] payload_out,
    output logic       payload_valid,
    output logic [7:0] cfg_out,
    output logic       ce_sync
);

    // Plain synchronisers; csn idles high so it resets high to avoid a false frame start.
    localparam logic [2:0] SYNC_RST = 3'b001;

    logic [2:0] async_in;
    logic [2:0] sync_out;
    assign async_in = {ce, mosi, csn};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] chain_q;
            always_ff @(posedge clk_in or posedge rst) begin
                if (rst) chain_q <= {SYNC_STAGES{SYNC_RST[gi]}};
                else     chain_q <= {chain_q[SYNC_STAGES-2:0], async_in[gi]};
            end
            assign sync_out[gi] = chain_q[SYNC_STAGES-1];
        end
    endgenerate

    logic csn_s, mosi_s;
    assign csn_s   = sync_out[0];
    assign mosi_s  = sync_out[1];
    assign ce_sync = sync_out[2];

    logic sck_s, sck_rise, sck_fall;
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
        .clk    (clk_in),
        .rst    (rst),
        .d_i    (sck),
        .sync_o (sck_s),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    logic csn_prev_q;
    logic csn_fall;
    assign csn_fall = csn_prev_q & ~csn_s;

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shin_q, shin_d;
    logic [7:0] shout_q, shout_d;
    logic       miso_q, miso_d;
    logic [4:0] addr_q, addr_d;
    logic       rxrd_q, rxrd_d;

    logic [7:0] regs_q [NUM_REGS];
    logic [7:0] rx_byte_q;
    logic       rx_dr_q, rx_dr_d;
    logic       tx_full_q, tx_full_d;
    logic [7:0] payload_q;
    logic       payload_valid_q;

    logic [7:0] byte_in;
    logic [7:0] status_now;
    logic [7:0] rd_val;
    logic       wr_commit, pl_commit, flush_tx, clr_rx;
    logic       reg_we, w1c_clr;

    assign byte_in    = {shin_q, mosi_s};
    assign status_now = status_byte(rx_dr_q, tx_full_q);

    always_comb begin
        rd_val = 8'h00;
        if (byte_in[4:3] == 2'b00) begin
            rd_val = (byte_in[2:0] == ADDR_STATUS[2:0]) ? status_now : regs_q[byte_in[2:0]];
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shin_d    = shin_q;
        shout_d   = shout_q;
        miso_d    = miso_q;
        addr_d    = addr_q;
        rxrd_d    = rxrd_q;
        wr_commit = 1'b0;
        pl_commit = 1'b0;
        flush_tx  = 1'b0;
        clr_rx    = 1'b0;

        if (csn_s) begin
            state_d = ST_IDLE;
            miso_d  = 1'b0;
        end else if (state_q == ST_IDLE) begin
            miso_d = 1'b0;
            if (csn_fall) begin
                state_d   = ST_CMD;
                shout_d   = status_now;
                miso_d    = status_now[7];
                bit_cnt_d = 3'd0;
            end
        end else if (sck_rise) begin
            shin_d    = byte_in[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                // Byte boundary: the next outgoing byte is loaded here and
                // its bit 7 goes out on the following falling edge.
                shout_d = 8'h00;
                state_d = ST_IGNORE;
                case (state_q)
                    ST_CMD: begin
                        rxrd_d = 1'b0;
                        if (byte_in[7:5] == OP_R_REGISTER) begin
                            state_d = ST_DATA_RD;
                            shout_d = rd_val;
                        end else if (byte_in[7:5] == OP_W_REGISTER) begin
                            state_d = ST_DATA_WR;
                            addr_d  = byte_in[4:0];
                        end else if (byte_in == OP_R_RX_PAYLOAD) begin
                            state_d = ST_DATA_RD;
                            shout_d = rx_byte_q;
                            rxrd_d  = 1'b1;
                        end else if (byte_in == OP_W_TX_PAYLOAD) begin
                            state_d = ST_DATA_PL;
                        end else if (byte_in == OP_FLUSH_TX) begin
                            flush_tx = 1'b1;
                        end else if (byte_in == OP_FLUSH_RX) begin
                            clr_rx = 1'b1;
                        end
                    end
                    ST_DATA_RD: clr_rx    = rxrd_q;
                    ST_DATA_WR: wr_commit = 1'b1;
                    ST_DATA_PL: pl_commit = 1'b1;
                    default:    ;
                endcase
            end
        end else if (sck_fall) begin
            if (bit_cnt_q == 3'd0) begin
                miso_d = shout_q[7];
            end else begin
                shout_d = {shout_q[6:0], 1'b0};
                miso_d  = shout_q[6];
            end
        end
    end

    assign reg_we  = wr_commit && (addr_q[4:3] == 2'b00) && (addr_q[2:0] != ADDR_STATUS[2:0]);
    assign w1c_clr = wr_commit && (addr_q == ADDR_STATUS) && byte_in[6];

    // A load in the same cycle as any clear wins, as does a payload commit over tx_ack.
    always_comb begin
        rx_dr_d = rx_dr_q;
        if (clr_rx || w1c_clr) rx_dr_d = 1'b0;
        if (rx_payload_load)   rx_dr_d = 1'b1;
        tx_full_d = tx_full_q;
        if (flush_tx || tx_ack) tx_full_d = 1'b0;
        if (pl_commit)          tx_full_d = 1'b1;
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            shin_q     <= 7'd0;
            shout_q    <= 8'h00;
            miso_q     <= 1'b0;
            addr_q     <= 5'd0;
            rxrd_q     <= 1'b0;
            csn_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shin_q     <= shin_d;
            shout_q    <= shout_d;
            miso_q     <= miso_d;
            addr_q     <= addr_d;
            rxrd_q     <= rxrd_d;
            csn_prev_q <= csn_s;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= reg_reset_val(3'(i), CONFIG_RST);
            end
            rx_byte_q       <= 8'h00;
            rx_dr_q         <= 1'b0;
            tx_full_q       <= 1'b0;
            payload_q       <= 8'h00;
            payload_valid_q <= 1'b0;
        end else begin
            if (reg_we) regs_q[addr_q[2:0]] <= byte_in;
            if (rx_payload_load) rx_byte_q <= rx_payload_in;
            if (pl_commit) payload_q <= byte_in;
            rx_dr_q         <= rx_dr_d;
            tx_full_q       <= tx_full_d;
            payload_valid_q <= pl_commit;
        end
    end

    assign miso          = miso_q;
    assign payload_out   = payload_q;
    assign payload_valid = payload_valid_q;
    assign cfg_out       = regs_q[0];

endmodule

// File: tb/tb_nrf_spi_responder.sv
// Directed bench for nrf_spi_responder: drives mode-0 SPI frames as a master
// and checks returned bytes, register effects, payload and flag behaviour.
module tb_nrf_spi_responder;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       csn = 1'b1;
    logic       sck = 1'b0;
    logic       mosi = 1'b0;
    logic       miso;
    logic       ce = 1'b0;
    logic [7:0] rx_payload_in = 8'h00;
    logic       rx_payload_load = 1'b0;
    logic       tx_ack = 1'b0;
    logic [7:0] payload_out;
    logic       payload_valid;
    logic [7:0] cfg_out;
    logic       ce_sync;

    int n_assert = 0;
    int n_fail   = 0;
    int pv_cnt   = 0;

    nrf_spi_responder #(.SYNC_STAGES(2), .CONFIG_RST(8'h08)) dut (
        .clk_in          (clk_in),
        .rst             (rst),
        .csn             (csn),
        .sck             (sck),
        .mosi            (mosi),
        .miso            (miso),
        .ce              (ce),
        .rx_payload_in   (rx_payload_in),
        .rx_payload_load (rx_payload_load),
        .tx_ack          (tx_ack),
        .payload_out     (payload_out),
        .payload_valid   (payload_valid),
        .cfg_out         (cfg_out),
        .ce_sync         (ce_sync)
    );

    always #10 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        if (payload_valid === 1'b1) pv_cnt <= pv_cnt + 1;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Shift nbits of tx (MSB first); miso is sampled just before each rising edge.
    task automatic xfer_bits(input logic [7:0] tx, input int nbits, input bit load_on_last,
                             output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            mosi = tx[i];
            #200;
            rx[i] = miso;
            sck = 1'b1;
            if (load_on_last && i == 0) begin
                // Lands the load strobe on the clock where the data byte commits.
                #50;
                rx_payload_load = 1'b1;
                #20;
                rx_payload_load = 1'b0;
                #130;
            end else begin
                #200;
            end
            sck = 1'b0;
        end
    endtask

    task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input int nbytes,
                         input bit load_on_last, output logic [7:0] r0, output logic [7:0] r1);
        csn = 1'b0;
        #200;
        xfer_bits(b0, 8, 1'b0, r0);
        r1 = 8'h00;
        if (nbytes > 1) xfer_bits(b1, 8, load_on_last, r1);
        #200;
        csn = 1'b1;
        #400;
        $display("frame %h %h -> %h %h", b0, b1, r0, r1);
    endtask

    task automatic pulse_load(input logic [7:0] v);
        rx_payload_in   = v;
        rx_payload_load = 1'b1;
        #20;
        rx_payload_load = 1'b0;
        #40;
    endtask

    initial begin
        logic [7:0] r0, r1;
        int pv_base;

        #105;
        rst = 1'b0;
        #100;
        chk("rst_miso", {7'd0, miso}, 8'h00);
        chk("rst_pvalid", {7'd0, payload_valid}, 8'h00);
        chk("rst_payload", payload_out, 8'h00);
        chk("rst_cfg", cfg_out, 8'h08);
        chk("rst_ce_sync", {7'd0, ce_sync}, 8'h00);

        frame(8'h00, 8'hFF, 2, 1'b0, r0, r1);
        chk("rd_cfg_status", r0, 8'h0E);
        chk("rd_cfg_data", r1, 8'h08);
        chk("cfg_out", cfg_out, 8'h08);

        frame(8'h25, 8'h4C, 2, 1'b0, r0, r1);
        frame(8'h05, 8'hFF, 2, 1'b0, r0, r1);
        chk("rd_rfch_status", r0, 8'h0E);
        chk("rd_rfch_data", r1, 8'h4C);
        frame(8'h3F, 8'hAB, 2, 1'b0, r0, r1);
        frame(8'h1F, 8'hFF, 2, 1'b0, r0, r1);
        chk("rd_addr1f", r1, 8'h00);
        frame(8'h05, 8'hFF, 2, 1'b0, r0, r1);
        chk("rfch_kept", r1, 8'h4C);
        frame(8'h07, 8'hFF, 2, 1'b0, r0, r1);
        chk("rd_status_reg", r1, 8'h0E);

        frame(8'hA0, 8'h5A, 2, 1'b0, r0, r1);
        chk("payload_out", payload_out, 8'h5A);
        chk("pvalid_cycles", 8'(pv_cnt), 8'h01);
        frame(8'hFF, 8'h00, 1, 1'b0, r0, r1);
        chk("nop_tx_full", r0, 8'h0F);
        tx_ack = 1'b1;
        #20;
        tx_ack = 1'b0;
        #40;
        frame(8'hFF, 8'h00, 1, 1'b0, r0, r1);
        chk("nop_after_ack", r0, 8'h0E);

        pulse_load(8'h3C);
        frame(8'hFF, 8'h00, 1, 1'b0, r0, r1);
        chk("nop_rx_dr", r0, 8'h40);
        frame(8'h61, 8'hFF, 2, 1'b0, r0, r1);
        chk("rxpl_status", r0, 8'h40);
        chk("rxpl_data", r1, 8'h3C);
        frame(8'hFF, 8'h00, 1, 1'b0, r0, r1);
        chk("nop_after_rxpl", r0, 8'h0E);

        pulse_load(8'h11);
        frame(8'h27, 8'h40, 2, 1'b0, r0, r1);
        chk("w1c_status", r0, 8'h40);
        frame(8'hFF, 8'h00, 1, 1'b0, r0, r1);
        chk("w1c_cleared", r0, 8'h0E);

        pulse_load(8'h22);
        rx_payload_in = 8'h77;
        frame(8'h27, 8'h40, 2, 1'b1, r0, r1);
        frame(8'hFF, 8'h00, 1, 1'b0, r0, r1);
        chk("w1c_vs_load", r0, 8'h40);
        frame(8'h61, 8'hFF, 2, 1'b0, r0, r1);
        chk("rxpl_reloaded", r1, 8'h77);
        pulse_load(8'h33);
        frame(8'hE2, 8'h00, 1, 1'b0, r0, r1);
        frame(8'hFF, 8'h00, 1, 1'b0, r0, r1);
        chk("flush_rx", r0, 8'h0E);

        ce = 1'b1;
        #100;
        chk("ce_sync_high", {7'd0, ce_sync}, 8'h01);

        csn = 1'b0;
        #200;
        xfer_bits(8'h21, 8, 1'b0, r0);
        xfer_bits(8'hAA, 5, 1'b0, r1);
        #200;
        csn = 1'b1;
        #400;
        $display("aborted write 21 + 5 bits");
        chk("abort_idle_miso", {7'd0, miso}, 8'h00);
        frame(8'h01, 8'hFF, 2, 1'b0, r0, r1);
        chk("abort_reg1", r1, 8'h3F);

        pv_base = pv_cnt;
        csn = 1'b0;
        #200;
        xfer_bits(8'hA0, 8, 1'b0, r0);
        xfer_bits(8'h55, 4, 1'b0, r1);
        rst = 1'b1;
        #40;
        chk("rst_mid_miso", {7'd0, miso}, 8'h00);
        csn = 1'b1;
        #100;
        rst = 1'b0;
        #200;
        $display("reset mid-frame during W_TX_PAYLOAD");
        chk("rst_mid_payload", payload_out, 8'h00);
        chk("rst_mid_pvalid", 8'(pv_cnt - pv_base), 8'h00);
        frame(8'h05, 8'hFF, 2, 1'b0, r0, r1);
        chk("rst_mid_rfch", r1, 8'h02);
        frame(8'h01, 8'hFF, 2, 1'b0, r0, r1);
        chk("rst_mid_reg1", r1, 8'h3F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
